// File: rtl/button_debouncer_pkg.sv
// Shared constants for the button debouncer: FSM state encoding and the
// default qualification window derived from the system clock frequency.
package button_debouncer_pkg;

  // System clock frequency used to derive time-based defaults.
  localparam int CLK_FREQ_HZ = 50_000_000;

  // Length of the qualification window in milliseconds.
  localparam int DEBOUNCE_MS = 10;

  // Consecutive equal samples needed before a level flips (10 ms at 50 MHz).
  localparam int DEFAULT_DEBOUNCE_CYCLES = (CLK_FREQ_HZ / 1000) * DEBOUNCE_MS;

  // Per-channel FSM states.
  typedef enum logic {
    STATE_STABLE = 1'b0,
    STATE_SETTLE = 1'b1
  } state_t;

endpackage

// File: rtl/button_debouncer_channel.sv
// One debounce channel: synchronizer chain, optional inversion, and a
// two-state qualification FSM with its own saturation-free counter.
module button_debouncer_channel
  import button_debouncer_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int INVERT        = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  output logic level_out,
  output logic settling
);

  localparam int               CW       = $clog2(STABLE_CYCLES);
  localparam logic             INV      = 1'(INVERT);
  localparam logic [CW-1:0]    CNT_LAST = CW'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sample;
  state_t                 r_state;
  logic [CW-1:0]          r_count;
  logic                   r_level;
  logic                   r_settling;

  // Synchronizer chain; reset value makes the post-inversion sample 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= {SYNC_STAGES{INV}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], raw_in};
    end
  end

  assign w_sample = r_sync[SYNC_STAGES-1] ^ INV;

  // Qualification FSM: a candidate level must persist STABLE_CYCLES cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= STATE_STABLE;
      r_count    <= '0;
      r_level    <= 1'b0;
      r_settling <= 1'b0;
    end else begin
      case (r_state)
        STATE_STABLE: begin
          if (w_sample != r_level) begin
            r_state    <= STATE_SETTLE;
            r_count    <= CW'(1);
            r_settling <= 1'b1;
          end else begin
            r_count <= '0;
          end
        end
        STATE_SETTLE: begin
          if (w_sample == r_level) begin
            // Bounce back to the current level: restart from scratch.
            r_state    <= STATE_STABLE;
            r_count    <= '0;
            r_settling <= 1'b0;
          end else if (r_count == CNT_LAST) begin
            r_level    <= ~r_level;
            r_state    <= STATE_STABLE;
            r_count    <= '0;
            r_settling <= 1'b0;
          end else begin
            r_count <= r_count + CW'(1);
          end
        end
        default: begin
          r_state    <= STATE_STABLE;
          r_count    <= '0;
          r_settling <= 1'b0;
        end
      endcase
    end
  end

  assign level_out = r_level;
  assign settling  = r_settling;

endmodule

// File: rtl/button_debouncer.sv
// Multi-channel debouncer: one fully independent channel per input bit,
// producing clean synchronous levels for a downstream edge detector.
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int CHANNELS      = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int INVERT        = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] raw_in,
  output logic [CHANNELS-1:0] level_out,
  output logic [CHANNELS-1:0] settling
);

  // One channel per input bit; no state is shared between channels.
  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      button_debouncer_channel #(
        .SYNC_STAGES   (SYNC_STAGES),
        .STABLE_CYCLES (STABLE_CYCLES),
        .INVERT        (INVERT)
      ) u_chan (
        .clk       (clk),
        .rst       (rst),
        .raw_in    (raw_in[gi]),
        .level_out (level_out[gi]),
        .settling  (settling[gi])
      );
    end
  endgenerate

endmodule
